// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the coordinate/colour types
// used by the raster scanner and its pixel strobe.
package vga_pkg;

   localparam int COLOR_W = 3;
   localparam int COORD_W = 11;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_SYNC_ACTIVE = 0;

   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
   localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/vga_pixel_strobe.sv
// Divides the system clock down to the pixel rate: pix_en is high for one
// clk out of every CLK_DIV (constantly high when CLK_DIV is 1).
module vga_pixel_strobe #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en
);

   localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

   logic [1:0] div_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg <= '0;
      end else if (div_reg == DIV_LAST) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_reg + 2'd1;
      end
   end

   assign pix_en = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_scanner.sv
// VGA raster generator: scans (x,y) for the renderer and registers its colour
// together with hsync/vsync so every DAC pin lags the coordinate by one pixel.
module vga_timing_scanner
   import vga_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int H_FP        = VGA_H_FP,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BP        = VGA_H_BP,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int V_FP        = VGA_V_FP,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BP        = VGA_V_BP,
   parameter int SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
   input  logic               clk,
   input  logic               rst,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic   SYNC_LEVEL = (SYNC_ACTIVE != 0);

   logic   pix_en;
   coord_t h_reg;
   coord_t v_reg;
   logic   hsync_reg;
   logic   vsync_reg;
   logic   frame_start_reg;
   logic   line_end;
   logic   frame_end;
   logic   active;
   logic   hs_on;
   logic   vs_on;

   vga_pixel_strobe #(
      .CLK_DIV (CLK_DIV)
   ) u_strobe (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en)
   );

   assign line_end  = (h_reg == H_LAST);
   assign frame_end = line_end && (v_reg == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_reg <= '0;
         v_reg <= '0;
      end else if (pix_en) begin
         h_reg <= line_end ? '0 : h_reg + coord_t'(1);
         if (line_end) begin
            v_reg <= frame_end ? '0 : v_reg + coord_t'(1);
         end
      end
   end

   assign x = h_reg;
   assign y = v_reg;

   // Decoded from the current counters; registered below so they line up with colour.
   assign active = (h_reg < H_ACT_C) && (v_reg < V_ACT_C);
   assign hs_on  = (h_reg >= HS_START) && (h_reg < HS_END);
   assign vs_on  = (v_reg >= VS_START) && (v_reg < VS_END);

   logic [2:0][COLOR_W-1:0] pix_ch;
   logic [2:0][COLOR_W-1:0] rgb_q;

   assign pix_ch = {pix_b, pix_g, pix_r};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         color_t chan_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               chan_reg <= '0;
            end else if (pix_en) begin
               chan_reg <= active ? pix_ch[gi] : '0;
            end
         end

         assign rgb_q[gi] = chan_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_reg       <= ~SYNC_LEVEL;
         vsync_reg       <= ~SYNC_LEVEL;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= pix_en && frame_end;
         if (pix_en) begin
            hsync_reg <= hs_on ? SYNC_LEVEL : ~SYNC_LEVEL;
            vsync_reg <= vs_on ? SYNC_LEVEL : ~SYNC_LEVEL;
         end
      end
   end

   assign vga_r       = rgb_q[0];
   assign vga_g       = rgb_q[1];
   assign vga_b       = rgb_q[2];
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_scanner.sv
// Bench for vga_timing_scanner: a full-size 640x480 instance at CLK_DIV=2 and a
// miniature-raster instance at CLK_DIV=1, both checked every clk against a pixel-count model.
module tb_vga_timing_scanner;

   typedef struct {
      int         n;
      logic [8:0] rgb;
      logic       hs;
      logic       vs;
      logic       fs;
   } mst_t;

   typedef struct {
      int div; int ht; int vt; int ha; int va;
      int hss; int hse; int vss; int vse;
   } tp_t;

   localparam int MODE_S = 2;

   tp_t tp_m = '{div:2, ht:800, vt:525, ha:640, va:480, hss:656, hse:752, vss:490, vse:492};
   tp_t tp_s = '{div:1, ht:25,  vt:13,  ha:16,  va:8,   hss:18,  hse:22,  vss:9,   vse:11};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode_m = 2;
   bit   ovr = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   mst_t ms_m;
   mst_t ms_s;

   logic [10:0] x_m, y_m, x_s, y_s;
   logic [2:0]  pr_m, pg_m, pb_m, pr_s, pg_s, pb_s;
   logic [2:0]  r_m, g_m, b_m, r_s, g_s, b_s;
   logic        hs_m, vs_m, fs_m, hs_s, vs_s, fs_s;

   always #5 clk = ~clk;

   // Renderer stand-in: 0 = single dot at (10,2), 1 = solid white, 2 = coordinate pattern.
   function automatic logic [8:0] colour(int mode, bit force_col, int px, int py);
      if (force_col) return 9'h092;
      case (mode)
         0:       return (px == 10 && py == 2) ? 9'h1FF : 9'h000;
         1:       return 9'h1FF;
         default: return {3'(px & 7), 3'(py & 7), 3'((px >> 3) & 7)};
      endcase
   endfunction

   function automatic mst_t rst_state();
      mst_t s;
      s.n = 0; s.rgb = '0; s.hs = 1'b1; s.vs = 1'b1; s.fs = 1'b0;
      return s;
   endfunction

   // One clk of the raster: every div-th clk is pixel k, which publishes pixel k-1.
   function automatic mst_t step(mst_t s, tp_t p, int mode, bit force_col);
      mst_t o = s;
      int k, px, py;
      o.n  = s.n + 1;
      o.fs = 1'b0;
      if (o.n % p.div == 0) begin
         k  = o.n / p.div;
         px = (k - 1) % p.ht;
         py = ((k - 1) / p.ht) % p.vt;
         o.rgb = (px < p.ha && py < p.va) ? colour(mode, force_col, px, py) : 9'h000;
         o.hs  = !(px >= p.hss && px < p.hse);
         o.vs  = !(py >= p.vss && py < p.vse);
         o.fs  = (k % (p.ht * p.vt) == 0);
      end
      return o;
   endfunction

   function automatic logic [33:0] pins(mst_t s, tp_t p);
      int k;
      k = s.n / p.div;
      return {11'(k % p.ht), 11'((k / p.ht) % p.vt), s.rgb, s.hs, s.vs, s.fs};
   endfunction

   task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tmo(input string nm, input bit ok);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: event not seen within its cycle budget (t=%0t)", nm, $time);
      end
   endtask

   assign {pr_m, pg_m, pb_m} = colour(mode_m, ovr, int'(x_m), int'(y_m));
   assign {pr_s, pg_s, pb_s} = colour(MODE_S, 1'b0, int'(x_s), int'(y_s));

   vga_timing_scanner dut_m (
      .clk (clk), .rst (rst), .x (x_m), .y (y_m),
      .pix_r (pr_m), .pix_g (pg_m), .pix_b (pb_m),
      .vga_r (r_m), .vga_g (g_m), .vga_b (b_m),
      .hsync (hs_m), .vsync (vs_m), .frame_start (fs_m)
   );

   vga_timing_scanner #(
      .CLK_DIV (1), .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
      .V_ACTIVE (8), .V_FP (1), .V_SYNC (2), .V_BP (2), .SYNC_ACTIVE (0)
   ) dut_s (
      .clk (clk), .rst (rst), .x (x_s), .y (y_s),
      .pix_r (pr_s), .pix_g (pg_s), .pix_b (pb_s),
      .vga_r (r_s), .vga_g (g_s), .vga_b (b_s),
      .hsync (hs_s), .vsync (vs_s), .frame_start (fs_s)
   );

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         ms_m = rst_state();
         ms_s = rst_state();
      end else begin
         ms_m = step(ms_m, tp_m, mode_m, ovr);
         ms_s = step(ms_s, tp_s, MODE_S, 1'b0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("pins_main", {x_m, y_m, r_m, g_m, b_m, hs_m, vs_m, fs_m}, pins(ms_m, tp_m));
         chk("pins_small", {x_s, y_s, r_s, g_s, b_s, hs_s, vs_s, fs_s}, pins(ms_s, tp_s));
      end
   end

   task automatic main_seq();
      int t, c0, cnt, xc;
      @(negedge clk);
      // Horizontal sync: placement, width and line period.
      t = 0; while (hs_m !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
      tmo("hs_fall", t < 4000);
      chk("hs_first_x", x_m, 657);
      c0 = cyc;
      cnt = 0; while (hs_m === 1'b0 && cnt < 400) begin @(negedge clk); cnt++; end
      chk("hs_width_clks", cnt, 192);
      t = 0; while (hs_m !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
      tmo("hs_fall2", t < 2000);
      chk("line_period", cyc - c0, 1600);
      // Single-dot alignment.
      mode_m = 0;
      t = 0; while (!(x_m == 11 && y_m == 2) && t < 4000) begin @(negedge clk); t++; end
      tmo("dot_wait", t < 4000);
      chk("dot_hit", {r_m, g_m, b_m}, 9'h1FF);
      repeat (2) @(negedge clk);
      chk("dot_after", {r_m, g_m, b_m}, 9'h000);
      // Solid fill and horizontal blanking.
      mode_m = 1;
      t = 0; while (!(x_m == 5 && y_m == 3) && t < 4000) begin @(negedge clk); t++; end
      tmo("fill_wait", t < 4000);
      chk("fill_active", {r_m, g_m, b_m}, 9'h1FF);
      t = 0; while (!(x_m == 700 && y_m == 3) && t < 2000) begin @(negedge clk); t++; end
      tmo("blank_wait", t < 2000);
      chk("fill_hblank", {r_m, g_m, b_m}, 9'h000);
      // Hold between strobes: colour change in the off-strobe clk only.
      t = 0; while (!(x_m == 20 && y_m == 4) && t < 4000) begin @(negedge clk); t++; end
      tmo("hold_wait", t < 4000);
      xc = int'(x_m);
      t = 0; while (int'(x_m) == xc && t < 4) begin @(negedge clk); t++; end
      tmo("hold_sync", t < 4);
      ovr = 1'b1;
      @(negedge clk);
      chk("hold_off_strobe", {r_m, g_m, b_m}, 9'h1FF);
      @(negedge clk);
      chk("hold_next_strobe", {r_m, g_m, b_m}, 9'h092);
      ovr = 1'b0;
      // Asynchronous reset mid-line, then restart latency.
      t = 0; while (x_m != 300 && t < 2000) begin @(negedge clk); t++; end
      tmo("rst_wait", t < 2000);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("rst_xy", {x_m, y_m}, 22'd0);
      chk("rst_rgb", {r_m, g_m, b_m}, 9'h000);
      chk("rst_sync_fs", {hs_m, vs_m, fs_m}, 3'b110);
      repeat (2) @(posedge clk); #2 rst = 1'b0;
      @(negedge clk); chk("start_n0", x_m, 0);
      @(negedge clk); chk("start_n1", x_m, 0);
      @(negedge clk); chk("start_n2", x_m, 1);
      // Reset while hsync is asserted.
      t = 0; while (!(x_m == 700 && hs_m === 1'b0) && t < 2000) begin @(negedge clk); t++; end
      tmo("rst_hs_wait", t < 2000);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("rst_hs", hs_m, 1);
      repeat (2) @(posedge clk); #2 rst = 1'b0;
      repeat (50) @(negedge clk);
   endtask

   task automatic small_seq();
      int t, c0, cnt;
      @(negedge clk);
      t = 0; while (!(x_s == 3 && y_s == 1) && t < 200) begin @(negedge clk); t++; end
      tmo("s_act_wait", t < 200);
      chk("s_active_rgb", {r_s, g_s, b_s}, 9'h088);
      t = 0; while (!(x_s == 3 && y_s == 9) && t < 400) begin @(negedge clk); t++; end
      tmo("s_vbl_wait", t < 400);
      chk("s_vblank_rgb", {r_s, g_s, b_s}, 9'h000);
      t = 0; while (fs_s !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      tmo("s_fs_wait", t < 400);
      chk("s_fs_xy", {x_s, y_s}, 22'd0);
      c0 = cyc;
      @(negedge clk);
      chk("s_fs_width", fs_s, 0);
      t = 0; while (fs_s !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      tmo("s_fs_wait2", t < 400);
      chk("s_frame_period", cyc - c0, 325);
      t = 0; while (vs_s !== 1'b0 && t < 400) begin @(negedge clk); t++; end
      tmo("s_vs_wait", t < 400);
      chk("s_vs_first", {x_s, y_s}, {11'd1, 11'd9});
      cnt = 0; while (vs_s === 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
      chk("s_vs_width", cnt, 50);
      t = 0; while (!(x_s == 24 && y_s == 12) && t < 400) begin @(negedge clk); t++; end
      tmo("s_wrap_wait", t < 400);
      @(negedge clk);
      chk("s_wrap", {x_s, y_s}, 22'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      fork
         main_seq();
         small_seq();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
